// File: rtl/ex_complete_unit_pkg.sv
// Shared types for the execute/complete stage: issue and remove packets,
// completion-queue entries, FU classes and default timing parameters.
package ex_complete_unit_pkg;

  localparam int TAG_W    = 6;
  localparam int RS_IDX_W = 4;

  localparam int DEF_MULT_STAGES = 4;
  localparam int DEF_MEM_LAT     = 3;
  localparam int DEF_CQ_DEPTH    = 8;

  typedef logic [TAG_W-1:0] TAG;

  typedef struct packed {
    logic valid;
    TAG   tag;
  } DEST_TAG;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;

  typedef struct packed {
    ALU_FUNC             alu_func;
    logic                rd_mem;
    logic                wr_mem;
    logic [RS_IDX_W-1:0] rs_idx;
    DEST_TAG             t;
  } DECODER_PACKET;

  typedef struct packed {
    logic          issue_en;
    DECODER_PACKET decoder_packet;
  } RS_IS_PACKET;

  typedef struct packed {
    logic                remove_en;
    logic [RS_IDX_W-1:0] remove_idx;
  } EX_RS_PACKET;

  typedef enum logic [1:0] {FU_ALU, FU_MULT, FU_MEM} FU_CLASS;

  typedef struct packed {
    TAG                  tag;
    logic                has_dest;
    logic [RS_IDX_W-1:0] rs_idx;
  } EX_CQ_ENTRY;

  // Multiply ops win over a (malformed) memory flag so they never occupy the MEM unit.
  function automatic FU_CLASS fu_class_of(input DECODER_PACKET p);
    if (p.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return FU_MULT;
    if (p.rd_mem || p.wr_mem) return FU_MEM;
    return FU_ALU;
  endfunction

endpackage

// File: rtl/ex_complete_unit_cq.sv
// ex_cq: completion queue with three ordered push ports and one pop port.
// Port 0 is written first, so push order is the port order.
module ex_cq
  import ex_complete_unit_pkg::*;
#(
  parameter  int DEPTH = DEF_CQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic       [2:0]       i_push_valid,
  input  EX_CQ_ENTRY [2:0]       i_push_data,
  input  logic                   i_pop,
  output logic       [CNT_W-1:0] o_count,
  output EX_CQ_ENTRY             o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  EX_CQ_ENTRY       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_push_cnt;
  logic [PTR_W-1:0] w_wr_idx [3];
  logic             w_do_pop;

  // Each valid port lands in the slot after all lower-numbered valid ports.
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      w_wr_idx[i] = r_wr_ptr + PTR_W'(w_push_cnt);
      w_push_cnt  = w_push_cnt + CNT_W'(i_push_valid[i]);
    end
  end

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clock) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_do_pop);
      r_count  <= r_count + w_push_cnt - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (i_push_valid[i]) r_mem[w_wr_idx[i]] <= i_push_data[i];
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

`ifndef SYNTHESIS
  a_cqNoOverflow: assert property (@(posedge clock) disable iff (!reset) r_count <= CNT_W'(DEPTH));
`endif

endmodule

// File: rtl/ex_complete_unit.sv
// Execute/complete unit: ALU, pipelined MULT and blocking MEM timing, credit-based
// issue stall, and CDB/RS-remove arbitration. Optional macro: EX_CQ_BYPASS_EN.
module ex_complete_unit
  import ex_complete_unit_pkg::*;
#(
  parameter int MULT_STAGES = DEF_MULT_STAGES,
  parameter int MEM_LAT     = DEF_MEM_LAT,
  parameter int CQ_DEPTH    = DEF_CQ_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt,
  input  RS_IS_PACKET rs_is_packet,
  output logic        is_stall,
  output TAG          cdb,
  output logic        cdb_en,
  output EX_RS_PACKET ex_rs_packet
);

  localparam int CNT_W  = $clog2(CQ_DEPTH + 1);
  localparam int MEM_CW = $clog2(MEM_LAT + 1);

  DECODER_PACKET          w_dp;
  FU_CLASS                w_class;
  EX_CQ_ENTRY             w_new_entry;
  logic                   w_flush;
  logic                   w_accept;
  logic                   w_mem_busy;
  logic [CNT_W:0]         w_credit_used;

  logic [MULT_STAGES-1:0] r_mult_valid;
  EX_CQ_ENTRY             r_mult_entry [MULT_STAGES];
  logic [MEM_CW-1:0]      r_mem_cnt;
  EX_CQ_ENTRY             r_mem_entry;
  logic                   r_alu_valid;
  EX_CQ_ENTRY             r_alu_entry;
  logic [CNT_W-1:0]       r_inflight;

  logic [2:0]             w_fin;
  logic [1:0]             w_fin_cnt;
  logic [2:0]             w_push_valid;
  EX_CQ_ENTRY [2:0]       w_push_data;
  logic [CNT_W-1:0]       w_cq_count;
  EX_CQ_ENTRY             w_cq_head;
  logic                   w_out_valid;
  EX_CQ_ENTRY             w_out_entry;

  assign w_dp        = rs_is_packet.decoder_packet;
  assign w_class     = fu_class_of(w_dp);
  assign w_new_entry = '{tag: w_dp.t.tag, has_dest: w_dp.t.valid && !w_dp.wr_mem, rs_idx: w_dp.rs_idx};
  assign w_flush     = !reset || interrupt;
  assign w_mem_busy  = (r_mem_cnt != '0);

  // Every accepted op owns a CQ slot until popped, so the queue cannot overflow.
  assign w_credit_used = {1'b0, w_cq_count} + {1'b0, r_inflight};
  assign is_stall = rs_is_packet.issue_en &&
                    ((w_credit_used >= (CNT_W+1)'(CQ_DEPTH)) || (w_class == FU_MEM && w_mem_busy));
  assign w_accept = rs_is_packet.issue_en && !is_stall;

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_mult_valid <= '0;
    end else begin
      r_mult_valid[0] <= w_accept && (w_class == FU_MULT);
      r_mult_entry[0] <= w_new_entry;
      for (int i = 1; i < MULT_STAGES; i++) begin
        r_mult_valid[i] <= r_mult_valid[i-1];
        r_mult_entry[i] <= r_mult_entry[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_mem_cnt <= '0;
    end else if (w_accept && (w_class == FU_MEM)) begin
      r_mem_cnt   <= MEM_CW'(MEM_LAT);
      r_mem_entry <= w_new_entry;
    end else if (w_mem_busy) begin
      r_mem_cnt <= r_mem_cnt - MEM_CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_alu_valid <= 1'b0;
    end else begin
      r_alu_valid <= w_accept && (w_class == FU_ALU);
      r_alu_entry <= w_new_entry;
    end
  end

  assign w_fin       = {r_alu_valid, (r_mem_cnt == MEM_CW'(1)), r_mult_valid[MULT_STAGES-1]};
  assign w_fin_cnt   = 2'(w_fin[0]) + 2'(w_fin[1]) + 2'(w_fin[2]);
  assign w_push_data = {r_alu_entry, r_mem_entry, r_mult_entry[MULT_STAGES-1]};

  // A finished op leaves the credit pool whether it is queued or bypassed.
  always_ff @(posedge clock) begin
    if (w_flush) r_inflight <= '0;
    else         r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_fin_cnt);
  end

  always_comb begin
    w_out_valid  = (w_cq_count != '0);
    w_out_entry  = w_cq_head;
    w_push_valid = w_fin;
`ifdef EX_CQ_BYPASS_EN
    if ((w_cq_count == '0) && (w_fin_cnt == 2'd1)) begin
      w_out_valid  = 1'b1;
      w_push_valid = '0;
      w_out_entry  = w_fin[0] ? w_push_data[0] : (w_fin[1] ? w_push_data[1] : w_push_data[2]);
    end
`endif
  end

  ex_cq #(.DEPTH(CQ_DEPTH)) u_cq (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (interrupt),
    .i_push_valid (w_push_valid),
    .i_push_data  (w_push_data),
    .i_pop        (w_cq_count != '0),
    .o_count      (w_cq_count),
    .o_head       (w_cq_head)
  );

  assign cdb                     = w_out_valid ? w_out_entry.tag : '0;
  assign cdb_en                  = w_out_valid && w_out_entry.has_dest;
  assign ex_rs_packet.remove_en  = w_out_valid;
  assign ex_rs_packet.remove_idx = w_out_valid ? w_out_entry.rs_idx : '0;

endmodule

// File: tb/tb_ex_complete_unit.sv
// Directed bench for ex_complete_unit with an ordered completion scoreboard and
// an independent credit/busy model for is_stall.
module tb_ex_complete_unit;
  import ex_complete_unit_pkg::*;

  localparam int MS    = 4;
  localparam int ML    = 3;
  localparam int DEPTH = 4;
`ifdef EX_CQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        interrupt = 1'b0;
  RS_IS_PACKET rs_is_packet = '0;
  logic        is_stall;
  TAG          cdb;
  logic        cdb_en;
  EX_RS_PACKET ex_rs_packet;

  typedef struct {
    int         fin;
    int         prio;
    logic [5:0] tag;
    logic       hasDest;
    logic [3:0] rs;
  } SbEntry;

  SbEntry sb[$];
  int cyc = 0;
  int lastOut = -10;
  int lastMem = -100;
  int checks = 0;
  int errors = 0;

  ex_complete_unit #(.MULT_STAGES(MS), .MEM_LAT(ML), .CQ_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .interrupt    (interrupt),
    .rs_is_packet (rs_is_packet),
    .is_stall     (is_stall),
    .cdb          (cdb),
    .cdb_en       (cdb_en),
    .ex_rs_packet (ex_rs_packet)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Output cycle of the oldest pending op: serialised one per cycle after its finish.
  function automatic int expOut();
    int nb = 0;
    foreach (sb[i]) if (sb[i].fin == sb[0].fin) nb++;
    if (BYP && (lastOut < sb[0].fin) && (nb == 1)) return sb[0].fin;
    return (sb[0].fin + 1 > lastOut + 1) ? sb[0].fin + 1 : lastOut + 1;
  endfunction

  task automatic sbInsert(input SbEntry n);
    int k = 0;
    while (k < sb.size() && (sb[k].fin < n.fin || (sb[k].fin == n.fin && sb[k].prio < n.prio))) k++;
    sb.insert(k, n);
  endtask

  always @(negedge clock) begin : monitor
    logic [11:0] expV;
    SbEntry e;
    expV = '0;
    if (sb.size() > 0) begin
      if (expOut() == cyc) begin
        e = sb.pop_front();
        expV = {e.tag, e.hasDest, 1'b1, e.rs};
        lastOut = cyc;
      end
    end
    checkOutput($sformatf("cdbOut@%0d", cyc), 32'({cdb, cdb_en, ex_rs_packet}), 32'(expV));
    if (!reset || interrupt) begin
      sb.delete();
      lastOut = cyc;
      lastMem = -100;
    end
  end

  task automatic applyStimulus(input ALU_FUNC f, input logic rd, input logic wr, input logic [5:0] tag,
                               input logic tv, input logic [3:0] rs, input logic intr);
    SbEntry n;
    int prio;
    int lat;
    logic expStall;
    @(posedge clock); #1;
    reset = 1'b1;
    interrupt = intr;
    rs_is_packet.issue_en = 1'b1;
    rs_is_packet.decoder_packet.alu_func = f;
    rs_is_packet.decoder_packet.rd_mem = rd;
    rs_is_packet.decoder_packet.wr_mem = wr;
    rs_is_packet.decoder_packet.rs_idx = rs;
    rs_is_packet.decoder_packet.t.valid = tv;
    rs_is_packet.decoder_packet.t.tag = tag;
    #1;
    if (f == ALU_MUL || f == ALU_MULH || f == ALU_MULHSU || f == ALU_MULHU) begin
      prio = 0; lat = MS;
    end else if (rd || wr) begin
      prio = 1; lat = ML;
    end else begin
      prio = 2; lat = 1;
    end
    expStall = (sb.size() >= DEPTH) || (prio == 1 && cyc > lastMem && cyc <= lastMem + ML);
    checkOutput($sformatf("is_stall@%0d", cyc), 32'(is_stall), 32'(expStall));
    if (!expStall) begin
      n = '{fin: cyc + lat, prio: prio, tag: tag, hasDest: tv && !wr, rs: rs};
      sbInsert(n);
      if (prio == 1) lastMem = cyc;
    end
  endtask

  task automatic idleCycles(input int n, input logic rst);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      reset = rst;
      interrupt = 1'b0;
      rs_is_packet.issue_en = 1'b0;
      #1;
      checkOutput($sformatf("is_stall_idle@%0d", cyc), 32'(is_stall), 32'(0));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idleCycles(2, 1'b0);

    applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'd12, 1'b1, 4'd3, 1'b0);
    idleCycles(4, 1'b1);

    applyStimulus(ALU_ADD, 1'b0, 1'b1, 6'd0, 1'b0, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(ALU_ADD, 1'b1, 1'b0, 6'd7, 1'b1, 4'd4, 1'b0);
    idleCycles(6, 1'b1);

    applyStimulus(ALU_MUL, 1'b0, 1'b0, 6'd20, 1'b1, 4'd5, 1'b0);
    idleCycles(2, 1'b1);
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'd21, 1'b1, 4'd6, 1'b0);
    idleCycles(6, 1'b1);

    for (int i = 0; i < 10; i++)
      applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'(24 + i), 1'b1, 4'(i), 1'b0);
    idleCycles(4, 1'b1);

    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3)      applyStimulus(ALU_ADD, 1'b1, 1'b0, 6'(32 + i), 1'b1, 4'(i), 1'b0);
      else if (i % 3 == 2) applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'(32 + i), 1'b1, 4'(i), 1'b0);
      else                 applyStimulus(ALU_MULH, 1'b0, 1'b0, 6'(32 + i), 1'b1, 4'(i), 1'b0);
    end
    idleCycles(12, 1'b1);

    applyStimulus(ALU_MUL, 1'b0, 1'b0, 6'd50, 1'b1, 4'd1, 1'b0);
    applyStimulus(ALU_MULHU, 1'b0, 1'b0, 6'd51, 1'b1, 4'd2, 1'b0);
    applyStimulus(ALU_ADD, 1'b1, 1'b0, 6'd52, 1'b1, 4'd3, 1'b0);
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'd53, 1'b1, 4'd4, 1'b1);
    idleCycles(3, 1'b1);
    applyStimulus(ALU_SUB, 1'b0, 1'b0, 6'd54, 1'b1, 4'd5, 1'b0);
    idleCycles(4, 1'b1);

    applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'd55, 1'b1, 4'd6, 1'b0);
    applyStimulus(ALU_MUL, 1'b0, 1'b0, 6'd56, 1'b1, 4'd7, 1'b0);
    applyStimulus(ALU_XOR, 1'b0, 1'b0, 6'd57, 1'b1, 4'd8, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 6'd58, 1'b1, 4'd9, 1'b0);
    idleCycles(8, 1'b1);

    checkOutput("drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_complete_unit.md
Name: ex_complete_unit

Overview:
- Execute-side partner of the reservation station; consumes its issue handshake (RS_IS_PACKET, is_stall).
- Models functional-unit latency for three classes: ALU, pipelined multiplier, non-pipelined memory unit.
- Arbitrates finished ops onto the single CDB (cdb, cdb_en) and returns EX_RS_PACKET remove requests so RS entries are freed.

Parameters:
- MULT_STAGES, 4, multiplier pipeline depth (>=1).
- MEM_LAT, 3, memory-unit busy cycles per op (>=1).
- CQ_DEPTH, 8, completion-queue entries (power of 2, >=4).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- interrupt  in  1  synchronous flush, active-high.
- rs_is_packet  in  RS_IS_PACKET  issue_en plus decoder_packet (alu_func, rd_mem, wr_mem, rs_idx, dest tag t).
- is_stall  out  1  issue refused this cycle.
- cdb  out  TAG  broadcast destination tag.
- cdb_en  out  1  cdb valid.
- ex_rs_packet  out  EX_RS_PACKET  remove_en, remove_idx.

Behaviour:
- Accept: issue_en && !is_stall in cycle c; captured at the clock edge ending cycle c.
- Class select:
  - MULT if alu_func is ALU_MUL, ALU_MULH, ALU_MULHSU or ALU_MULHU.
  - MEM if rd_mem or wr_mem.
  - ALU otherwise.
- has_dest = dest tag t.valid && !wr_mem.
- ALU: single register stage; op is finished in cycle c+1.
- MULT: MULT_STAGES-deep shift register of {valid, tag, has_dest, rs_idx}; accepts one op per cycle; finished in cycle c+MULT_STAGES.
- MEM: down-counter loaded with MEM_LAT on accept; busy while nonzero; finished in the cycle the counter reads 1.
- Completion queue (CQ):
  - Multi-push (up to 3 per cycle), single-pop FIFO.
  - Push order for simultaneous finishes: MULT, then MEM, then ALU.
  - Finished ops are written at the end of their finish cycle.
- Pop: whenever the CQ is non-empty, the head is driven combinationally and popped at the edge:
  - cdb = head.tag; cdb_en = head.has_dest.
  - ex_rs_packet.remove_en = 1; remove_idx = head.rs_idx.
  - Stores therefore free their RS entry with cdb_en=0.
- Empty CQ: cdb_en=0, remove_en=0, cdb=0, remove_idx=0.
- Latency with an empty CQ: ALU result on CDB in c+2; MULT in c+1+MULT_STAGES; MEM in c+1+MEM_LAT.
- Credits:
  - inflight = ops accepted but not yet pushed.
  - is_stall = issue_en && ((cq_count + inflight >= CQ_DEPTH) || (class==MEM && mem_busy)).
  - Combinational from the input packet. Guarantees no CQ overflow.
  - is_stall=0 whenever issue_en=0.
- Simultaneous push and pop on the same edge is legal; count = count + pushes - pop.
- Pointers wrap modulo CQ_DEPTH.
- Reset (reset==0) or interrupt at the edge:
  - Clear all FU stages, the MEM counter, CQ pointers/count and inflight.
  - Outputs read 0 in the following cycle.
  - An op accepted in the same cycle as the flush is discarded.
- Reset values: cdb=0, cdb_en=0, ex_rs_packet=0, is_stall=0.
- Assertion (sim only): cq_count never exceeds CQ_DEPTH.

Optional Feature:
- Macro EX_CQ_BYPASS_EN.
- Defined:
  - When the CQ is empty and exactly one FU finishes this cycle, that op drives cdb/cdb_en/ex_rs_packet combinationally in its finish cycle and is not pushed.
  - ALU latency becomes c+1. Credits count a bypassed op as retired that cycle.
  - With multiple finishers, all are pushed (no bypass).
- Undefined: all finishers go through the CQ; latencies as above.

Decomposition:
- Shared package / sys_defs.svh:
  - FU_CLASS enum {FU_ALU, FU_MULT, FU_MEM}.
  - EX_CQ_ENTRY struct {tag, has_dest, rs_idx}.
  - MULT_STAGES, MEM_LAT and CQ_DEPTH default macros.
  - EX_RS_PACKET definition shared with the RS.
- Sub-module ex_cq: parameterised 3-push/1-pop FIFO exposing count, head and per-port push-valid.
- Class decode, FU timing and credits stay in the top module.

Test Plan:
- Single ALU op (ADD, tag 12, rs_idx 3) issued cycle 0 -> cycle 2: cdb=12, cdb_en=1, remove_idx=3; idle after.
- Store (wr_mem, rs_idx 2) cycle 0 -> cycle 4: remove_en=1, remove_idx=2, cdb_en=0. Second MEM op in cycles 1-3 -> is_stall=1.
- MUL (tag 20) cycle 0, then ADD (tag 21) in cycle 3 -> both finish cycle 4. CDB shows 20 in cycle 5, then 21 in cycle 6.
- Back-to-back ADDs every cycle with CQ_DEPTH=4 -> sustained one CDB per cycle, is_stall never 1. With a MULT every cycle plus an ALU-heavy mix -> is_stall rises at count+inflight=4 and no entry is lost.
- Interrupt while 3 ops are in flight -> next cycle cdb_en=0, remove_en=0, cq_count=0. A post-flush ADD completes at the normal latency.
- reset=0 for 2 cycles mid-stream -> all outputs 0. With EX_CQ_BYPASS_EN, a lone ADD in cycle 0 -> cdb in cycle 1.
